fifo_wptr_full_ctrl: RTL

- Write-side pointer and flag controller for the async FIFO. It is the source end of the gray-pointer crossing.
- Owns the write binary counter and generates the registered gray write pointer. That pointer is sent to the read domain through the two-flop synchronizer.
- Consumes the read pointer already synchronized into the write domain. From it, produces full, almost-full and fill level for the writer and the memory write enable/address.

---
 rtl/fifo_wptr_full_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/fifo_wptr_full_ctrl.sv
// fifo_wptr_full_ctrl
// Write-side pointer and flag controller for an asynchronous FIFO. It owns
// the binary write counter, produces the registered gray write pointer that
// crosses into the read domain, and derives full, almost-full and fill level
// from the read pointer already synchronized into this clock domain.
//
// Build option: define FIFO_WOVERFLOW_EN to build the sticky overflow
// detector. Without it, woverflow is tied low.

module fifo_wptr_full_ctrl #(
  parameter int addr_size_p    = 8,
  parameter int afull_thresh_p = 2**addr_size_p - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   winc,
  input  logic [addr_size_p:0]   wq2_rptr,
  output logic                   wen,
  output logic [addr_size_p-1:0] waddr,
  output logic [addr_size_p:0]   wptr,
  output logic                   wfull,
  output logic                   walmost_full,
  output logic [addr_size_p:0]   wlevel,
  output logic                   woverflow
);

  typedef logic [addr_size_p:0] ptr_t;

  localparam ptr_t afull_thresh_lp = ptr_t'(afull_thresh_p);

  ptr_t wbin;
  ptr_t wbinnext;
  ptr_t wgraynext;
  ptr_t full_ptr;
  ptr_t rbin;
  ptr_t level_next;

  // A write is accepted only when the FIFO is not already full.
  assign wen   = winc & ~wfull;
  assign waddr = wbin[addr_size_p-1:0];

  // Next binary and gray write pointers; the counter wraps naturally.
  assign wbinnext  = wbin + ptr_t'(wen);
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // The write pointer is exactly one lap ahead of the read pointer when the
  // two top gray bits are inverted and the remaining bits match.
  assign full_ptr = {~wq2_rptr[addr_size_p:addr_size_p-1],
                     wq2_rptr[addr_size_p-2:0]};

  // Gray-to-binary conversion of the synchronized read pointer: each binary
  // bit is the XOR of all gray bits from the MSB down to that position.
  always_comb begin
    // NOTE: assigning a default first guarantees every bit is written on
    // every pass, so no latch is inferred.
    rbin = '0;
    for (int i = 0; i <= addr_size_p; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Fill level seen after this edge; may overstate the true fill because
  // the read pointer arrives late, which is the safe direction.
  assign level_next = wbinnext - rbin;

  // Pointer and flag registers, all updated from the next-state values so
  // full asserts on the same edge that writes the last slot.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order. Only control
    // state is reset here; the FIFO storage itself lives elsewhere and needs
    // no reset because the pointers define which entries are valid.
    if (rst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= (wgraynext == full_ptr);
      walmost_full <= (level_next >= afull_thresh_lp);
      wlevel       <= level_next;
    end
  end

`ifdef FIFO_WOVERFLOW_EN
  // Sticky overflow: a write attempted while full sets it until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      woverflow <= 1'b0;
    end else if (winc && wfull) begin
      woverflow <= 1'b1;
    end
  end
`else
  assign woverflow = 1'b0;
`endif

endmodule
